ro_trng_bank: RTL and testbench

RO_TRNG_BANK -- requirements
Module: ro_trng_bank

---
 rtl/ro_trng_bank.sv | 185 ++++++++++++++++++
 tb/tb_ro_trng_bank.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ro_trng_bank.sv
// ro_trng_bank
//   Ring-oscillator true random number generator. NUM_RO free-running rings
//   (or ext_bits in bypass test mode) are synchronised, sampled on a
//   programmable tick, XOR-combined into one raw bit, optionally von Neumann
//   debiased, and packed LSB-in into OUT_W-bit words. A repetition-count
//   health test runs on the raw bit stream.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous reset, active-high (1 = in reset)
//   enable       run the rings and the collection path
//   bypass       use ext_bits instead of the ring taps (rings are stopped)
//   ext_bits     external entropy substitutes, one per ring
//   div          sample tick every div+1 clocks
//   vn_en        enable the von Neumann debiaser
//   data_out     random word, stable while data_valid=1
//   data_valid   data_out holds an unconsumed word
//   data_ready   consumer accepts the word
//   overrun      sticky: a completed word was dropped
//   health_fail  sticky: repetition-count test tripped
//
// RO_LOOP_EN=0 builds the rings as open (static) chains. Cycle-based
// simulators cannot settle a free-running zero-delay loop, so models that
// only exercise bypass mode set it to 0; silicon builds keep the default.
module ro_trng_bank #(
    parameter int NUM_RO     = 4,
    parameter int RO_STAGES  = 5,
    parameter int OUT_W      = 8,
    parameter int DIV_W      = 8,
    parameter int REP_LIMIT  = 16,
    parameter bit RO_LOOP_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              bypass,
    input  logic [NUM_RO-1:0] ext_bits,
    input  logic [DIV_W-1:0]  div,
    input  logic              vn_en,
    output logic [OUT_W-1:0]  data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              overrun,
    output logic              health_fail
);

    localparam int BCNT_W = $clog2(OUT_W + 1);
    localparam int REP_W  = $clog2(REP_LIMIT + 1);
    localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(OUT_W);
    localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REP_LIMIT);

    // Saturating increment for the repetition counter.
    function automatic logic [REP_W-1:0] sat_rep_inc(input logic [REP_W-1:0] v);
        if (v >= REP_MAX) return REP_MAX;
        return v + REP_W'(1);
    endfunction

    // Rings are stopped in bypass as well, so test mode is quiet.
    logic              ro_run;
    logic [NUM_RO-1:0] ro_tap;
    logic [NUM_RO-1:0] src_bits;

    assign ro_run = enable & ~bypass;

    for (genvar g = 0; g < NUM_RO; g++) begin : g_ring
        (* keep = "true" *) logic [RO_STAGES-1:0] inv;
        (* keep = "true" *) logic                 fb;
        if (RO_LOOP_EN) begin : g_loop
            assign fb = inv[RO_STAGES-1];
        end else begin : g_open
            assign fb = 1'b0;
        end
        assign inv[0] = ~(fb & ro_run);
        for (genvar s = 1; s < RO_STAGES; s++) begin : g_stage
            assign inv[s] = ~inv[s-1];
        end
        assign ro_tap[g] = inv[RO_STAGES-1];
    end

    assign src_bits = bypass ? ext_bits : ro_tap;

    // ---- stage p0/p1: two-flop synchroniser, enable travels alongside ----
    logic [NUM_RO-1:0] sync_p0, sync_p1;
    logic              vld_p0, vld_p1;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            sync_p0 <= src_bits;
            sync_p1 <= sync_p0;
            vld_p0  <= enable;
            vld_p1  <= vld_p0;
        end
    end

    // ---- stage p2: tick, raw bit, debias, collect, hand off ----
    logic [DIV_W-1:0]  div_cnt;
    logic [BCNT_W-1:0] bit_cnt;
    logic [OUT_W-1:0]  sreg;
    logic [REP_W-1:0]  rep_cnt;
    logic              prev_raw;
    logic              vn_phase;
    logic              vn_first;

    logic              run, tick, raw_bit, emit, emit_bit, word_done;
    logic [REP_W-1:0]  rep_nxt;

    // Collection only starts once synchroniser contents came from an
    // enabled source, so no stale bits enter a word.
    assign run       = enable & vld_p1;
    assign tick      = run && (div_cnt == div);
    assign raw_bit   = ^sync_p1;
    assign word_done = (bit_cnt == BCNT_FULL);

    always_comb begin
        emit     = 1'b0;
        emit_bit = raw_bit;
        if (tick) begin
            if (!vn_en) begin
                emit = 1'b1;
            end else if (vn_phase && (vn_first != raw_bit)) begin
                emit     = 1'b1;
                emit_bit = vn_first;
            end
        end
    end

    always_comb begin
        rep_nxt = REP_W'(1);
        if ((rep_cnt != '0) && (raw_bit == prev_raw)) rep_nxt = sat_rep_inc(rep_cnt);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            sreg        <= '0;
            rep_cnt     <= '0;
            prev_raw    <= 1'b0;
            vn_phase    <= 1'b0;
            vn_first    <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            overrun     <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            if (!run || tick) div_cnt <= '0;
            else              div_cnt <= div_cnt + DIV_W'(1);

            if (!run) begin
                vn_phase <= 1'b0;
                rep_cnt  <= '0;
            end else if (tick) begin
                vn_phase <= ~vn_phase;
                vn_first <= raw_bit;
                prev_raw <= raw_bit;
                rep_cnt  <= rep_nxt;
                if (rep_nxt == REP_MAX) health_fail <= 1'b1;
            end

            if (emit) sreg <= {sreg[OUT_W-2:0], emit_bit};

            // A bit emitted on the load clock becomes bit 1 of the next word.
            if (!run)           bit_cnt <= '0;
            else if (word_done) bit_cnt <= emit ? BCNT_W'(1) : '0;
            else if (emit)      bit_cnt <= bit_cnt + BCNT_W'(1);

            if (word_done) begin
                if (!data_valid || data_ready) begin
                    data_out   <= sreg;
                    data_valid <= 1'b1;
                end else begin
                    overrun    <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ro_trng_bank.sv
module tb_ro_trng_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       bypass = 1'b1;
    logic [3:0] ext_bits = 4'b0001;
    logic [7:0] div = 8'd0;
    logic       vn_en = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b0;
    logic       overrun;
    logic       health_fail;

    int tests = 0;
    int fails = 0;

    // raw pairs 10,01,00,11,10,01,10,01,10,01 ; bit i is the i-th raw bit
    logic [19:0] vn_raw = 20'b1001_1001_1001_1100_1001;

    ro_trng_bank #(
        .NUM_RO(4), .RO_STAGES(5), .OUT_W(8), .DIV_W(8), .REP_LIMIT(16),
        .RO_LOOP_EN(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bypass(bypass),
        .ext_bits(ext_bits), .div(div), .vn_en(vn_en),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .overrun(overrun), .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Assert reset mid-cycle, check outputs clear at once, release after an edge.
    task automatic do_reset();
        enable = 1'b0;
        rst_n  = 1'b1;
        #1;
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(data_valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_health", 32'(health_fail), 32'h0);
        step(1);
        rst_n = 1'b0;
    endtask

    initial begin
        // Reset state and constant raw=1 word timing
        step(3);
        chk("init_data_out", 32'(data_out), 32'h0);
        chk("init_valid", 32'(data_valid), 32'h0);
        chk("init_overrun", 32'(overrun), 32'h0);
        chk("init_health", 32'(health_fail), 32'h0);
        rst_n = 1'b0;
        step(3);
        enable = 1'b1;
        step(10);
        chk("const_valid_c10", 32'(data_valid), 32'h0);
        step(1);
        chk("const_valid_c11", 32'(data_valid), 32'h1);
        chk("const_word", 32'(data_out), 32'hFF);
        chk("const_health", 32'(health_fail), 32'h0);
        data_ready = 1'b1;
        step(1);
        chk("xfer_valid_fall", 32'(data_valid), 32'h0);
        data_ready = 1'b0;

        // Alternating raw bits, overrun, same-clock reload, health test
        do_reset();
        for (int i = 0; i < 11; i++) begin
            ext_bits = (i % 2 == 0) ? 4'b0011 : 4'b0001;
            if (i == 0) enable = 1'b1;
            step(1);
        end
        chk("alt_valid", 32'(data_valid), 32'h1);
        chk("alt_word", 32'(data_out), 32'h55);
        chk("alt_health", 32'(health_fail), 32'h0);
        ext_bits = 4'b0001;
        step(7);
        chk("ovr_before", 32'(overrun), 32'h0);
        step(1);
        chk("ovr_set", 32'(overrun), 32'h1);
        chk("ovr_word_held", 32'(data_out), 32'h55);
        chk("ovr_valid_held", 32'(data_valid), 32'h1);
        step(7);
        chk("ovr_word_still", 32'(data_out), 32'h55);
        data_ready = 1'b1;
        step(1);
        chk("reload_word", 32'(data_out), 32'hFF);
        chk("reload_valid", 32'(data_valid), 32'h1);
        step(1);
        chk("reload_valid_fall", 32'(data_valid), 32'h0);
        chk("rep15_health", 32'(health_fail), 32'h0);
        data_ready = 1'b0;
        step(1);
        chk("rep16_health", 32'(health_fail), 32'h1);
        for (int i = 0; i < 4; i++) begin
            ext_bits = i[0] ? 4'b0001 : 4'b0011;
            step(1);
        end
        chk("health_sticky", 32'(health_fail), 32'h1);
        chk("overrun_sticky", 32'(overrun), 32'h1);

        // Von Neumann debiaser
        do_reset();
        vn_en = 1'b1;
        for (int i = 0; i < 23; i++) begin
            ext_bits = (i < 20) ? {3'b000, vn_raw[i]} : 4'b0000;
            if (i == 0) enable = 1'b1;
            step(1);
            if (i == 21) chk("vn_valid_c22", 32'(data_valid), 32'h0);
        end
        chk("vn_valid_c23", 32'(data_valid), 32'h1);
        chk("vn_word", 32'(data_out), 32'hAA);
        chk("vn_health", 32'(health_fail), 32'h0);

        // Disable keeps the word; handshake still completes
        enable = 1'b0;
        step(2);
        chk("dis_word_kept", 32'(data_out), 32'hAA);
        chk("dis_valid_kept", 32'(data_valid), 32'h1);
        data_ready = 1'b1;
        step(1);
        chk("dis_xfer", 32'(data_valid), 32'h0);
        data_ready = 1'b0;

        // div=3 with reset after five bits
        div      = 8'd3;
        vn_en    = 1'b0;
        ext_bits = 4'b0001;
        enable   = 1'b1;
        step(23);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_word", 32'(data_out), 32'h0);
        chk("mid_rst_valid", 32'(data_valid), 32'h0);
        chk("mid_rst_overrun", 32'(overrun), 32'h0);
        chk("mid_rst_health", 32'(health_fail), 32'h0);
        step(1);
        rst_n = 1'b0;
        step(34);
        chk("div3_valid_c34", 32'(data_valid), 32'h0);
        step(1);
        chk("div3_valid_c35", 32'(data_valid), 32'h1);
        chk("div3_word", 32'(data_out), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
